// File: rtl/ex_mem_skid_reg.sv
// EX->MEM stage register with a two-entry skid buffer.
// Registered in_ready decouples EX from MEM stalls; flush squashes held entries.
module ex_mem_skid_reg #(
    parameter int DW = 8,
    parameter int RW = 3,
    parameter int CW = 8
) (
    input  logic          clk2,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_alu,
    input  logic [DW-1:0] in_stdata,
    input  logic [RW-1:0] in_dest,
    input  logic          in_memwrite,
    input  logic          in_memread,
    input  logic          in_memtoreg,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_alu,
    output logic [DW-1:0] out_stdata,
    output logic [RW-1:0] out_dest,
    output logic          out_memwrite,
    output logic          out_memread,
    output logic          out_memtoreg,
    output logic [1:0]    occupancy,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic          rdy_q;
    logic          vld_q;
    logic [1:0]    occ_q;
    logic [CW-1:0] stall_q;

    logic [DW-1:0] m_alu, m_st;
    logic [RW-1:0] m_dest;
    logic          m_mw, m_mr, m_mtr;

    logic [DW-1:0] s_alu, s_st;
    logic [RW-1:0] s_dest;
    logic          s_mw, s_mr, s_mtr;

    logic acc;
    logic pop;

    assign acc = in_valid & rdy_q;
    assign pop = vld_q & out_ready;

    // State, handshake flags, storage and stall counter in one registered block
    always_ff @(posedge clk2) begin
        if (!rst_n) begin
            state   <= EMPTY;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            occ_q   <= 2'd0;
            stall_q <= '0;
            m_alu   <= '0;
            m_st    <= '0;
            m_dest  <= '0;
            m_mw    <= 1'b0;
            m_mr    <= 1'b0;
            m_mtr   <= 1'b0;
            s_alu   <= '0;
            s_st    <= '0;
            s_dest  <= '0;
            s_mw    <= 1'b0;
            s_mr    <= 1'b0;
            s_mtr   <= 1'b0;
        end else begin
            if (vld_q && !out_ready && stall_q != {CW{1'b1}})
                stall_q <= stall_q + 1'b1;
            if (flush) begin
                state <= EMPTY;
                rdy_q <= 1'b1;
                vld_q <= 1'b0;
                occ_q <= 2'd0;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (acc) begin
                            m_alu  <= in_alu;
                            m_st   <= in_stdata;
                            m_dest <= in_dest;
                            m_mw   <= in_memwrite;
                            m_mr   <= in_memread;
                            m_mtr  <= in_memtoreg;
                            state  <= ONE;
                            vld_q  <= 1'b1;
                            occ_q  <= 2'd1;
                        end
                    end
                    ONE: begin
                        if (acc && pop) begin
                            m_alu  <= in_alu;
                            m_st   <= in_stdata;
                            m_dest <= in_dest;
                            m_mw   <= in_memwrite;
                            m_mr   <= in_memread;
                            m_mtr  <= in_memtoreg;
                        end else if (acc) begin
                            s_alu  <= in_alu;
                            s_st   <= in_stdata;
                            s_dest <= in_dest;
                            s_mw   <= in_memwrite;
                            s_mr   <= in_memread;
                            s_mtr  <= in_memtoreg;
                            state  <= FULL;
                            rdy_q  <= 1'b0;
                            occ_q  <= 2'd2;
                        end else if (pop) begin
                            state <= EMPTY;
                            vld_q <= 1'b0;
                            occ_q <= 2'd0;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            m_alu  <= s_alu;
                            m_st   <= s_st;
                            m_dest <= s_dest;
                            m_mw   <= s_mw;
                            m_mr   <= s_mr;
                            m_mtr  <= s_mtr;
                            state  <= ONE;
                            rdy_q  <= 1'b1;
                            occ_q  <= 2'd1;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        rdy_q <= 1'b1;
                        vld_q <= 1'b0;
                        occ_q <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign in_ready     = rdy_q;
    assign out_valid    = vld_q;
    assign occupancy    = occ_q;
    assign stall_cnt    = stall_q;
    assign out_alu      = m_alu;
    assign out_stdata   = m_st;
    assign out_dest     = m_dest;
    assign out_memwrite = m_mw & vld_q;
    assign out_memread  = m_mr & vld_q;
    assign out_memtoreg = m_mtr & vld_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed and random checks of ex_mem_skid_reg against a FIFO scoreboard.
// Outputs are sampled on the falling edge; inputs change 1 time unit after rising.
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic [7:0] alu;
        logic [7:0] st;
        logic [2:0] dest;
        logic       mw;
        logic       mr;
        logic       mtr;
    } ent_t;

    logic       clk2 = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_alu;
    logic [7:0] in_stdata;
    logic [2:0] in_dest;
    logic       in_memwrite;
    logic       in_memread;
    logic       in_memtoreg;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_alu;
    logic [7:0] out_stdata;
    logic [2:0] out_dest;
    logic       out_memwrite;
    logic       out_memread;
    logic       out_memtoreg;
    logic [1:0] occupancy;
    logic [7:0] stall_cnt;

    ex_mem_skid_reg #(.DW(8), .RW(3), .CW(8)) dut (
        .clk2(clk2),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_alu(in_alu),
        .in_stdata(in_stdata),
        .in_dest(in_dest),
        .in_memwrite(in_memwrite),
        .in_memread(in_memread),
        .in_memtoreg(in_memtoreg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_alu(out_alu),
        .out_stdata(out_stdata),
        .out_dest(out_dest),
        .out_memwrite(out_memwrite),
        .out_memread(out_memread),
        .out_memtoreg(out_memtoreg),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk2 = ~clk2;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   m_stall  = 0;
    ent_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] s,
                         input logic [2:0] d, input logic w, input logic r, input logic t);
        in_valid    = v;
        in_alu      = a;
        in_stdata   = s;
        in_dest     = d;
        in_memwrite = w;
        in_memread  = r;
        in_memtoreg = t;
    endtask

    // One clock: check outputs against the model, then advance the model
    task automatic cycle();
        int   occ;
        logic acc;
        logic pop;
        ent_t e;
        @(negedge clk2);
        occ = q.size();
        chk("out_valid", 32'(out_valid), 32'(occ != 0));
        chk("in_ready", 32'(in_ready), 32'(occ != 2));
        chk("occupancy", 32'(occupancy), 32'(occ));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (occ != 0) begin
            chk("out_alu", 32'(out_alu), 32'(q[0].alu));
            chk("out_stdata", 32'(out_stdata), 32'(q[0].st));
            chk("out_dest", 32'(out_dest), 32'(q[0].dest));
            chk("out_memwrite", 32'(out_memwrite), 32'(q[0].mw));
            chk("out_memread", 32'(out_memread), 32'(q[0].mr));
            chk("out_memtoreg", 32'(out_memtoreg), 32'(q[0].mtr));
        end else begin
            chk("ctl_idle", 32'({out_memwrite, out_memread, out_memtoreg}), 32'(0));
        end
        acc = in_valid && (occ != 2);
        pop = (occ != 0) && out_ready;
        e = '{in_alu, in_stdata, in_dest, in_memwrite, in_memread, in_memtoreg};
        @(posedge clk2);
        if (occ != 0 && !out_ready && m_stall != 255)
            m_stall++;
        if (pop)
            void'(q.pop_front());
        if (flush)
            q.delete();
        else if (acc) begin
            q.push_back(e);
            n_pushed++;
        end
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset held for two cycles
        @(posedge clk2);
        @(posedge clk2);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_occupancy", 32'(occupancy), 32'(0));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
        chk("rst_payload", 32'({out_alu, out_stdata, out_dest}), 32'(0));
        chk("rst_ctl", 32'({out_memwrite, out_memread, out_memtoreg}), 32'(0));
        rst_n = 1'b1;

        // Pass-through with latency one
        out_ready = 1'b1;
        drive(1'b1, 8'h3C, 8'h00, 3'd5, 1'b0, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("pt_out_valid", 32'(out_valid), 32'(1));
        chk("pt_out_alu", 32'(out_alu), 32'(8'h3C));
        chk("pt_out_memread", 32'(out_memread), 32'(1));
        chk("pt_out_dest", 32'(out_dest), 32'(5));
        cycle();
        chk("pt_occ_after", 32'(occupancy), 32'(0));
        cycle();

        // Skid fill under stall, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'hA1, 3'd1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h22, 8'hA2, 3'd2, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h33, 8'hA3, 3'd3, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("skid_occ", 32'(occupancy), 32'(2));
        chk("skid_in_ready", 32'(in_ready), 32'(0));
        chk("skid_hold_alu", 32'(out_alu), 32'(8'h11));
        chk("skid_stall", 32'(stall_cnt), 32'(3));
        out_ready = 1'b1;
        cycle();
        chk("skid_second", 32'(out_alu), 32'(8'h22));
        cycle();
        cycle();
        chk("skid_drained", 32'(out_valid), 32'(0));

        // Flush with a store held and another offered
        out_ready = 1'b0;
        drive(1'b1, 8'h44, 8'hB4, 3'd4, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h55, 8'hB5, 3'd6, 1'b1, 1'b0, 1'b0);
        cycle();
        flush = 1'b1;
        drive(1'b1, 8'hEE, 8'hBE, 3'd7, 1'b1, 1'b0, 1'b0);
        cycle();
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("fl_out_valid", 32'(out_valid), 32'(0));
        chk("fl_memwrite", 32'(out_memwrite), 32'(0));
        chk("fl_occ", 32'(occupancy), 32'(0));
        chk("fl_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        repeat (3) cycle();

        // Stall counter saturation
        out_ready = 1'b0;
        drive(1'b1, 8'h66, 8'hC6, 3'd2, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (300) cycle();
        chk("sat_stall", 32'(stall_cnt), 32'(8'hFF));
        repeat (5) cycle();
        chk("sat_hold", 32'(stall_cnt), 32'(8'hFF));
        out_ready = 1'b1;
        repeat (2) cycle();

        // Random traffic, 1000 accepted entries
        n_pushed = 0;
        for (int c = 0; c < 20000 && n_pushed < 1000; c++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("rnd_pushed", 32'(n_pushed), 32'(1000));
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("rnd_empty", 32'(occupancy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
